debounce_sync: RTL and testbench



---
 rtl/debounce_sync.sv | 103 ++++++++++
 tb/tb_debounce_sync.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stability qualifier. dout changes only
// after STABLE_CYCLES consecutive synchronized samples disagree with it.
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_async,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= RESET_VAL;
      s2_q    <= RESET_VAL;
      dout_q  <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_STABLE;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    s1_d    = din_async;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      ST_STABLE: begin
        if (s2_q != dout_q) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        // A sample agreeing with dout mid-qualification means the change was a glitch.
        if (s2_q == dout_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          dout_d  = ~dout_q;
          rise_d  = ~dout_q;
          fall_d  = dout_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_WAIT);
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboarded bench for debounce_sync: a window-based reference model predicts
// dout/rise/fall/busy per edge, and a negedge monitor compares the DUT against it.
module tb_debounce_sync;

  localparam int N    = 4;
  localparam bit RV   = 1'b0;
  localparam int MAXE = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_async = 1'b0;
  logic dout, rise, fall, busy;

  debounce_sync #(
    .STABLE_CYCLES(N),
    .RESET_VAL(RV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din_async(din_async),
    .dout(dout),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  always #2 clk = ~clk;

  // Expected {dout, rise, fall, busy} per edge, plus that edge's index.
  logic [3:0] exp_q[$];
  int         exp_e[$];

  bit din_a[MAXE];
  bit samp_a[MAXE];
  int t          = 0;
  int rst_edge   = -1;
  int last_event = 0;
  bit m_dout     = RV;

  int checks = 0;
  int errors = 0;

  // The qualifier sees the level captured two edges earlier (RESET_VAL if a
  // reset intervened). dout flips once the last N samples since the previous
  // flip/reset all disagree with it.
  function automatic void model_edge(input bit d, input bit r);
    logic [3:0] e;
    bit flip;
    bit smp;
    din_a[t] = d;
    if (r) begin
      m_dout     = RV;
      rst_edge   = t;
      last_event = t;
      e          = {RV, 3'b000};
    end else begin
      smp       = (t - 2 > rst_edge) ? din_a[t-2] : RV;
      samp_a[t] = smp;
      flip      = (t - last_event >= N);
      for (int k = 0; k < N; k++) begin
        if (flip && samp_a[t-k] == m_dout) flip = 1'b0;
      end
      if (flip) begin
        m_dout     = ~m_dout;
        last_event = t;
        e          = {m_dout, m_dout, ~m_dout, 1'b0};
      end else begin
        e = {m_dout, 2'b00, smp != m_dout};
      end
    end
    exp_q.push_back(e);
    exp_e.push_back(t);
    t++;
  endfunction

  task automatic step(input bit d, input bit r);
    @(negedge clk);
    din_async = d;
    rst       = r;
    @(posedge clk);
    model_edge(d, r);
  endtask

  // Monitor: every cycle presents a result; compare it against the oldest prediction.
  initial begin
    logic [3:0] e;
    logic [3:0] got;
    int         en;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        en  = exp_e.pop_front();
        got = {dout, rise, fall, busy};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL edge_%0d dout/rise/fall/busy: got %b required %b", en, got, e);
        end else begin
          $display("edge %0d din=%b rst=%b dout=%b rise=%b fall=%b busy=%b ok",
                   en, din_a[en], rst, dout, rise, fall, busy);
        end
      end
    end
  end

  initial begin
    bit d;
    bit r;
    int len;

    // Reset with din high, then release: rise expected 5 edges after release.
    repeat (2) step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    // Clean fall, then clean rise, then clean fall again.
    repeat (10) step(1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    // Glitch of 3 samples must be rejected.
    repeat (3) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    // Reset in the middle of a qualification, din stays high.
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    // Chatter every cycle, then hold high.
    for (int i = 0; i < 20; i++) step(bit'(i % 2), 1'b0);
    repeat (10) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    // Two-cycle pulses and exactly-N-long holds around the threshold.
    repeat (2) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    repeat (N) step(1'b1, 1'b0);
    repeat (N) step(1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0);

    // Randomized hold lengths with occasional resets.
    repeat (150) begin
      d   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      r   = ($urandom_range(0, 39) == 0);
      if (r) step(d, 1'b1);
      repeat (len) step(d, 1'b0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
